// File: rtl/flash_playback_ctrl.sv
// Flash audio playback sequencer: fetches 32-bit words over the flash
// read handshake and releases one 16-bit half per accepted sample tick.
module flash_playback_ctrl #(
  parameter logic [22:0] START_ADDR = 23'h0,
  parameter logic [22:0] MAX_ADDR   = 23'h7FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        play_pause,
  input  logic        direction,
  input  logic        restart,
  input  logic        sample_tick,
  output logic        flash_read,
  output logic [22:0] flash_address,
  input  logic        flash_waitrequest,
  input  logic        flash_readdatavalid,
  input  logic [31:0] flash_readdata,
  output logic [15:0] audio_sample,
  output logic        audio_valid,
  output logic        playing
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_TICK1 = 3'd3;
  localparam logic [2:0] S_TICK2 = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        playing_q, playing_d;
  logic [22:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic        wdir_q, wdir_d;
  logic        pend_q, pend_d;
  logic [15:0] sample_q, sample_d;
  logic        valid_q, valid_d;

  logic [22:0] rst_addr;
  logic [22:0] step_addr;
  logic [15:0] half_first;
  logic [15:0] half_second;
  logic        emit;

  always_comb begin
    rst_addr = direction ? MAX_ADDR : START_ADDR;
    if (direction)
      step_addr = (addr_q == START_ADDR) ? MAX_ADDR : addr_q - 23'd1;
    else
      step_addr = (addr_q == MAX_ADDR) ? START_ADDR : addr_q + 23'd1;
    half_first  = wdir_q ? word_q[31:16] : word_q[15:0];
    half_second = wdir_q ? word_q[15:0] : word_q[31:16];
    emit        = sample_tick && playing_q;
  end

  always_comb begin
    state_d   = state_q;
    playing_d = playing_q ^ play_pause;
    addr_d    = addr_q;
    word_d    = word_q;
    wdir_d    = wdir_q;
    pend_d    = pend_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (restart)
          addr_d = rst_addr;
        if (playing_d)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (restart)
          pend_d = 1'b1;
        if (!flash_waitrequest)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (restart)
          pend_d = 1'b1;
        // a restart seen during the transaction discards the returned word
        if (flash_readdatavalid) begin
          if (pend_q || restart) begin
            pend_d  = 1'b0;
            addr_d  = rst_addr;
            state_d = playing_d ? S_FETCH : S_IDLE;
          end else begin
            word_d  = flash_readdata;
            wdir_d  = direction;
            state_d = S_TICK1;
          end
        end
      end
      S_TICK1, S_TICK2: begin
        if (restart) begin
          addr_d  = rst_addr;
          word_d  = '0;
          state_d = playing_d ? S_FETCH : S_IDLE;
        end else if (emit) begin
          valid_d = 1'b1;
          if (state_q == S_TICK1) begin
            sample_d = half_first;
            state_d  = S_TICK2;
          end else begin
            sample_d = half_second;
            addr_d   = step_addr;
            state_d  = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      playing_q <= 1'b0;
      addr_q    <= START_ADDR;
      word_q    <= '0;
      wdir_q    <= 1'b0;
      pend_q    <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      playing_q <= playing_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      wdir_q    <= wdir_d;
      pend_q    <= pend_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign flash_read    = (state_q == S_FETCH);
  assign flash_address = addr_q;
  assign audio_sample  = sample_q;
  assign audio_valid   = valid_q;
  assign playing       = playing_q;

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Directed bench for flash_playback_ctrl with an expected-sample queue
// and address model checked every cycle.
module tb_flash_playback_ctrl;

  localparam logic [22:0] START = 23'h0;
  localparam logic [22:0] MAXA  = 23'h7FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        play_pause = 1'b0;
  logic        direction = 1'b0;
  logic        restart = 1'b0;
  logic        sample_tick = 1'b0;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest = 1'b0;
  logic        flash_readdatavalid = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic [15:0] audio_sample;
  logic        audio_valid;
  logic        playing;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic [22:0] m_addr;

  flash_playback_ctrl dut (
    .clock               (clock),
    .reset               (reset),
    .play_pause          (play_pause),
    .direction           (direction),
    .restart             (restart),
    .sample_tick         (sample_tick),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_sample        (audio_sample),
    .audio_valid         (audio_valid),
    .playing             (playing)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] next_addr(input logic [22:0] a,
                                            input logic dir);
    int unsigned span;
    int unsigned off;
    span = int'(MAXA) - int'(START) + 1;
    off  = int'(a) - int'(START);
    off  = dir ? (off + span - 1) % span : (off + 1) % span;
    return START + 23'(off);
  endfunction

  function automatic void push_word(input logic [31:0] w, input logic dir);
    if (dir) begin
      exp_q.push_back(w[31:16]);
      exp_q.push_back(w[15:0]);
    end else begin
      exp_q.push_back(w[15:0]);
      exp_q.push_back(w[31:16]);
    end
  endfunction

  // every cycle: emitted samples vs queue, and request stability on stall
  logic        prev_stall = 1'b0;
  logic [22:0] prev_addr = '0;
  always @(negedge clock) begin
    if (audio_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got sample %h expected no output",
                 audio_sample);
      end else begin
        chk("sample", 32'(audio_sample), 32'(exp_q.pop_front()));
      end
    end
    if (prev_stall)
      chk("req_hold", {8'h0, flash_read, flash_address},
          {8'h0, 1'b1, prev_addr});
    prev_stall = flash_read && flash_waitrequest && !reset;
    prev_addr  = flash_address;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_pp();
    play_pause = 1'b1;
    step();
    play_pause = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] w, input int nwait, input int lat,
                       input bit rst_mid, input bit keep);
    int k;
    k = 0;
    while (!flash_read && k < 20) begin
      step();
      k++;
    end
    chk("fetch_start", 32'(flash_read), 32'd1);
    chk("fetch_addr", 32'(flash_address), 32'(m_addr));
    flash_waitrequest = 1'b1;
    for (int i = 0; i < nwait; i++) begin
      step();
      chk("read_held", 32'(flash_read), 32'd1);
    end
    flash_waitrequest = 1'b0;
    step();
    chk("read_drop", 32'(flash_read), 32'd0);
    if (rst_mid) begin
      restart = 1'b1;
      step();
      restart = 1'b0;
      repeat (lat - 2) step();
    end else begin
      repeat (lat - 1) step();
    end
    flash_readdatavalid = 1'b1;
    flash_readdata = w;
    step();
    flash_readdatavalid = 1'b0;
    if (rst_mid)
      m_addr = direction ? MAXA : START;
    else if (keep)
      push_word(w, direction);
  endtask

  task automatic play_word(input logic [31:0] w);
    fetch(w, 0, 1, 1'b0, 1'b1);
    tick();
    tick();
    m_addr = next_addr(m_addr, direction);
  endtask

  initial begin
    int guard;
    m_addr = START;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst_read", 32'(flash_read), 32'd0);
    chk("rst_addr", 32'(flash_address), 32'(START));
    chk("rst_sample", 32'(audio_sample), 32'd0);
    chk("rst_valid", 32'(audio_valid), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);

    // basic fetch with 3 stall cycles and 2-cycle data latency
    pulse_pp();
    chk("t1_playing", 32'(playing), 32'd1);
    fetch(32'hBBBB_AAAA, 3, 2, 1'b0, 1'b1);
    tick();
    chk("t1_s0", 32'(audio_sample), 32'h0000_AAAA);
    chk("t1_v0", 32'(audio_valid), 32'd1);
    step();
    chk("t1_v0_off", 32'(audio_valid), 32'd0);
    tick();
    chk("t1_s1", 32'(audio_sample), 32'h0000_BBBB);
    m_addr = next_addr(m_addr, direction);
    chk("t1_next", 32'(flash_address), 32'd1);

    // pause between halves
    fetch(32'h2222_1111, 1, 1, 1'b0, 1'b0);
    exp_q.push_back(16'h1111);
    tick();
    pulse_pp();
    chk("t3_paused", 32'(playing), 32'd0);
    repeat (5) tick();
    chk("t3_noread", 32'(flash_read), 32'd0);
    chk("t3_addr", 32'(flash_address), 32'd1);
    exp_q.push_back(16'h2222);
    pulse_pp();
    chk("t3_resumed", 32'(playing), 32'd1);
    tick();
    chk("t3_s1", 32'(audio_sample), 32'h0000_2222);
    m_addr = next_addr(m_addr, direction);
    chk("t3_next", 32'(flash_address), 32'd2);

    // walk forward to 0x1234
    guard = 0;
    while (m_addr != 23'h1234 && guard < 6000) begin
      play_word({~m_addr[15:0], m_addr[15:0]});
      guard++;
    end
    chk("walk_addr", 32'(m_addr), 32'h1234);

    // restart during WAIT_DATA
    fetch(32'hCAFE_F00D, 2, 3, 1'b1, 1'b0);
    chk("t4_read", 32'(flash_read), 32'd1);
    chk("t4_addr", 32'(flash_address), 32'd0);

    // restart and tick together in TICK1
    fetch(32'h5555_6666, 0, 1, 1'b0, 1'b0);
    restart = 1'b1;
    sample_tick = 1'b1;
    step();
    restart = 1'b0;
    sample_tick = 1'b0;
    m_addr = START;
    chk("t5_valid", 32'(audio_valid), 32'd0);
    chk("t5_read", 32'(flash_read), 32'd1);
    chk("t5_addr", 32'(flash_address), 32'(START));

    // wrap at both ends of the region
    direction = 1'b1;
    fetch(32'h0BAD_0BAD, 0, 2, 1'b1, 1'b0);
    chk("t2_max", 32'(m_addr), 32'h7FFFF);
    direction = 1'b0;
    play_word(32'hDEAD_BEEF);
    chk("t2_fwd_wrap", 32'(flash_address), 32'h0);
    direction = 1'b1;
    fetch(32'h1234_5678, 0, 1, 1'b0, 1'b1);
    tick();
    chk("t2_rev_hi", 32'(audio_sample), 32'h0000_1234);
    tick();
    chk("t2_rev_lo", 32'(audio_sample), 32'h0000_5678);
    m_addr = next_addr(m_addr, direction);
    chk("t2_rev_wrap", 32'(flash_address), 32'h7FFFF);

    // reset in the middle of a stalled fetch
    flash_waitrequest = 1'b1;
    step();
    chk("t6_pre", 32'(flash_read), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    flash_waitrequest = 1'b0;
    chk("t6_read", 32'(flash_read), 32'd0);
    chk("t6_playing", 32'(playing), 32'd0);
    chk("t6_sample", 32'(audio_sample), 32'd0);
    chk("t6_addr", 32'(flash_address), 32'(START));
    flash_readdatavalid = 1'b1;
    flash_readdata = 32'hFFFF_EEEE;
    step();
    flash_readdatavalid = 1'b0;
    repeat (3) step();
    chk("t6_valid", 32'(audio_valid), 32'd0);
    chk("t6_idle", 32'(flash_read), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
